// File: rtl/axi_write_arbiter.sv
// Round-robin arbiter that funnels NUM_REQ AXI write requesters onto one AW/W port.
// One burst is owned at a time: IDLE arbitrates, ADDR forwards AW once, DATA forwards BURST_LENGTH W beats.
module axi_write_arbiter #(
    parameter  int NUM_REQ       = 4,
    parameter  int AXI_DATAWIDTH = 64,
    parameter  int AXI_ADDRWIDTH = 32,
    parameter  int AXI_IDWIDTH   = 4,
    parameter  int AXI_USERWIDTH = 1,
    parameter  int BURST_LENGTH  = 8,
    localparam int DW = AXI_DATAWIDTH,
    localparam int AW = AXI_ADDRWIDTH,
    localparam int IW = AXI_IDWIDTH,
    localparam int UW = AXI_USERWIDTH,
    localparam int SW = AXI_DATAWIDTH / BURST_LENGTH,
    localparam int GW = $clog2(NUM_REQ),
    localparam int BW = $clog2(BURST_LENGTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_REQ-1:0]    s_aw_valid,
    output logic [NUM_REQ-1:0]    s_aw_ready,
    input  logic [NUM_REQ*IW-1:0] s_aw_id,
    input  logic [NUM_REQ*UW-1:0] s_aw_user,
    input  logic [NUM_REQ*AW-1:0] s_aw_addr,
    input  logic [NUM_REQ-1:0]    s_w_valid,
    output logic [NUM_REQ-1:0]    s_w_ready,
    input  logic [NUM_REQ-1:0]    s_w_last,
    input  logic [NUM_REQ*IW-1:0] s_w_id,
    input  logic [NUM_REQ*UW-1:0] s_w_user,
    input  logic [NUM_REQ*DW-1:0] s_w_data,
    input  logic [NUM_REQ*SW-1:0] s_w_strb,
    output logic                  m_aw_valid,
    input  logic                  m_aw_ready,
    output logic [IW-1:0]         m_aw_id,
    output logic [UW-1:0]         m_aw_user,
    output logic [AW-1:0]         m_aw_addr,
    output logic                  m_w_valid,
    input  logic                  m_w_ready,
    output logic [IW-1:0]         m_w_id,
    output logic [UW-1:0]         m_w_user,
    output logic [DW-1:0]         m_w_data,
    output logic [SW-1:0]         m_w_strb,
    output logic                  m_w_last,
    output logic [GW-1:0]         grant_idx,
    output logic                  busy,
    output logic                  burst_err,
    output logic [1:0]            o_dbg_state
);
    // Handshakes: a transfer happens on a rising edge where valid && ready; valid never waits on ready.
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_ADDR = 2'd1, ST_DATA = 2'd2} state_t;

    state_t        r_state, w_next;
    logic [GW-1:0] r_grant, r_ptr, w_winner;
    logic [BW-1:0] r_beat;
    logic          r_err;
    logic          w_w_hs, w_found;
    int            w_idx;

    logic [IW-1:0] w_aw_id   [NUM_REQ];
    logic [UW-1:0] w_aw_user [NUM_REQ];
    logic [AW-1:0] w_aw_addr [NUM_REQ];
    logic [IW-1:0] w_w_id    [NUM_REQ];
    logic [UW-1:0] w_w_user  [NUM_REQ];
    logic [DW-1:0] w_w_data  [NUM_REQ];
    logic [SW-1:0] w_w_strb  [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign w_aw_id[g]   = s_aw_id[g*IW +: IW];
        assign w_aw_user[g] = s_aw_user[g*UW +: UW];
        assign w_aw_addr[g] = s_aw_addr[g*AW +: AW];
        assign w_w_id[g]    = s_w_id[g*IW +: IW];
        assign w_w_user[g]  = s_w_user[g*UW +: UW];
        assign w_w_data[g]  = s_w_data[g*DW +: DW];
        assign w_w_strb[g]  = s_w_strb[g*SW +: SW];
    end

    // First requesting index at or above the pointer, wrapping at NUM_REQ-1.
    always_comb begin
        w_winner = r_ptr;
        w_found  = 1'b0;
        w_idx    = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = int'(r_ptr) + k;
            if (w_idx >= NUM_REQ) w_idx = w_idx - NUM_REQ;
            if (!w_found && s_aw_valid[w_idx]) begin
                w_found  = 1'b1;
                w_winner = GW'(w_idx);
            end
        end
    end

    always_comb begin
        w_next     = r_state;
        s_aw_ready = '0;
        s_w_ready  = '0;
        m_aw_valid = 1'b0;
        m_aw_id    = '0;
        m_aw_user  = '0;
        m_aw_addr  = '0;
        m_w_valid  = 1'b0;
        m_w_id     = '0;
        m_w_user   = '0;
        m_w_data   = '0;
        m_w_strb   = '0;
        m_w_last   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (|s_aw_valid) w_next = ST_ADDR;
            end
            ST_ADDR: begin
                m_aw_valid          = s_aw_valid[r_grant];
                m_aw_id             = w_aw_id[r_grant];
                m_aw_user           = w_aw_user[r_grant];
                m_aw_addr           = w_aw_addr[r_grant];
                s_aw_ready[r_grant] = m_aw_ready;
                if (m_aw_valid && m_aw_ready) w_next = ST_DATA;
            end
            ST_DATA: begin
                m_w_valid          = s_w_valid[r_grant];
                m_w_id             = w_w_id[r_grant];
                m_w_user           = w_w_user[r_grant];
                m_w_data           = w_w_data[r_grant];
                m_w_strb           = w_w_strb[r_grant];
                m_w_last           = (r_beat == BW'(BURST_LENGTH - 1));
                s_w_ready[r_grant] = m_w_ready;
                if (m_w_valid && m_w_ready && m_w_last) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    assign w_w_hs = m_w_valid && m_w_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_grant <= '0;
            r_ptr   <= '0;
            r_beat  <= '0;
            r_err   <= 1'b0;
        end else begin
            r_err <= w_w_hs && (s_w_last[r_grant] != m_w_last);
            if (r_state == ST_IDLE && (|s_aw_valid)) r_grant <= w_winner;
            // Burst length is a power of two, so the counter wraps to 0 on the last beat by itself.
            if (w_w_hs) r_beat <= r_beat + 1'b1;
            if (w_w_hs && m_w_last)
                r_ptr <= (r_grant == GW'(NUM_REQ - 1)) ? '0 : r_grant + 1'b1;
        end
    end

    assign grant_idx   = r_grant;
    assign busy        = (r_state != ST_IDLE);
    assign burst_err   = r_err;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_axi_write_arbiter.sv
// Scoreboarded bench for axi_write_arbiter: a requester model drives bursts, a monitor
// checks every downstream AW/W transfer against the expected queue in order.
module tb_axi_write_arbiter;
    localparam int N  = 4;
    localparam int DW = 64;
    localparam int AW = 32;
    localparam int IW = 4;
    localparam int UW = 1;
    localparam int BL = 8;
    localparam int SW = DW / BL;
    localparam int EW = 76;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    s_aw_valid, s_aw_ready, s_w_valid, s_w_ready, s_w_last;
    logic [N*IW-1:0] s_aw_id, s_w_id;
    logic [N*UW-1:0] s_aw_user, s_w_user;
    logic [N*AW-1:0] s_aw_addr;
    logic [N*DW-1:0] s_w_data;
    logic [N*SW-1:0] s_w_strb;
    logic            m_aw_valid, m_aw_ready, m_w_valid, m_w_ready, m_w_last;
    logic [IW-1:0]   m_aw_id, m_w_id;
    logic [UW-1:0]   m_aw_user, m_w_user;
    logic [AW-1:0]   m_aw_addr;
    logic [DW-1:0]   m_w_data;
    logic [SW-1:0]   m_w_strb;
    logic [1:0]      grant_idx;
    logic            busy, burst_err;
    logic [1:0]      o_dbg_state;

    always #5 clk = ~clk;

    axi_write_arbiter #(
        .NUM_REQ(N), .AXI_DATAWIDTH(DW), .AXI_ADDRWIDTH(AW),
        .AXI_IDWIDTH(IW), .AXI_USERWIDTH(UW), .BURST_LENGTH(BL)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .s_aw_valid(s_aw_valid), .s_aw_ready(s_aw_ready), .s_aw_id(s_aw_id),
        .s_aw_user(s_aw_user), .s_aw_addr(s_aw_addr),
        .s_w_valid(s_w_valid), .s_w_ready(s_w_ready), .s_w_last(s_w_last),
        .s_w_id(s_w_id), .s_w_user(s_w_user), .s_w_data(s_w_data), .s_w_strb(s_w_strb),
        .m_aw_valid(m_aw_valid), .m_aw_ready(m_aw_ready), .m_aw_id(m_aw_id),
        .m_aw_user(m_aw_user), .m_aw_addr(m_aw_addr),
        .m_w_valid(m_w_valid), .m_w_ready(m_w_ready), .m_w_id(m_w_id), .m_w_user(m_w_user),
        .m_w_data(m_w_data), .m_w_strb(m_w_strb), .m_w_last(m_w_last),
        .grant_idx(grant_idx), .busy(busy), .burst_err(burst_err), .o_dbg_state(o_dbg_state)
    );

    logic [EW-1:0] exp_q[$];
    int            checks = 0;
    int            passes = 0;
    int            w_hs_cnt = 0;
    int            err_pulses = 0;

    // Requester model state
    int          left[N], bnum[N], beat[N], base[N];
    bit          aw_done[N];
    logic [BL-1:0] last_mask[N];
    bit          exp_err;

    task automatic check(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [DW-1:0] mk_data(input int i, input int b, input int k);
        return {40'd0, 8'(i), 8'(b), 8'(k)};
    endfunction

    task automatic drive_all();
        for (int i = 0; i < N; i++) begin
            s_aw_valid[i]            = (left[i] > 0) && !aw_done[i];
            s_aw_addr[i*AW +: AW]    = AW'(base[i] + bnum[i] * 256);
            s_aw_id[i*IW +: IW]      = IW'(i);
            s_aw_user[i*UW +: UW]    = UW'(i);
            s_w_valid[i]             = (left[i] > 0);
            s_w_id[i*IW +: IW]       = IW'(i);
            s_w_user[i*UW +: UW]     = UW'(i);
            s_w_data[i*DW +: DW]     = mk_data(i, bnum[i], beat[i]);
            s_w_strb[i*SW +: SW]     = 8'h01 << beat[i];
            s_w_last[i]              = last_mask[i][beat[i]];
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < N; i++) begin
            left[i] = 0; bnum[i] = 0; beat[i] = 0; base[i] = 0;
            aw_done[i] = 1'b0; last_mask[i] = 8'h80;
        end
        exp_err = 1'b0;
        drive_all();
    endtask

    task automatic load(input int i, input int n, input int b, input logic [BL-1:0] mask);
        left[i] = n; bnum[i] = 0; beat[i] = 0; base[i] = b;
        aw_done[i] = 1'b0; last_mask[i] = mask;
        drive_all();
    endtask

    task automatic expect_burst(input int i, input int b, input int nbeats);
        logic [7:0] st;
        logic       lst;
        exp_q.push_back({1'b0, 2'(i), 1'b0, 8'(i), 32'd0, 32'(base[i] + b * 256)});
        for (int k = 0; k < nbeats; k++) begin
            st  = 8'h01 << k;
            lst = (k == BL - 1);
            exp_q.push_back({1'b1, 2'(i), lst, st, mk_data(i, b, k)});
        end
    endtask

    // One clock: sample handshakes at negedge, advance the model after the rising edge.
    task automatic step();
        logic [N-1:0] aw_hs, w_hs;
        @(negedge clk);
        aw_hs = s_aw_valid & s_aw_ready;
        w_hs  = s_w_valid & s_w_ready;
        if (exp_err || burst_err) check("burst_err", EW'(burst_err), EW'(exp_err));
        exp_err = 1'b0;
        for (int i = 0; i < N; i++)
            if (w_hs[i] && (s_w_last[i] != (beat[i] == BL - 1))) exp_err = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (aw_hs[i]) aw_done[i] = 1'b1;
            if (w_hs[i]) begin
                beat[i]++;
                if (beat[i] == BL) begin
                    beat[i] = 0; bnum[i]++; left[i]--; aw_done[i] = 1'b0;
                end
            end
        end
        drive_all();
    endtask

    function automatic bit any_left();
        for (int i = 0; i < N; i++) if (left[i] > 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic run_until_done(input int budget);
        int n = 0;
        while (any_left() && n < budget) begin
            step();
            n++;
        end
        if (any_left()) begin
            checks++;
            $display("FAIL timeout: requests still pending after %0d cycles, required none", budget);
        end
    endtask

    // Monitor: pops the expected queue on every downstream transfer.
    task automatic sb_pop(input string name, input logic [EW-1:0] act);
        if (exp_q.size() == 0) begin
            checks++;
            $display("FAIL %s: unexpected transfer %0h, required no transfer", name, act);
        end else begin
            check(name, act, exp_q.pop_front());
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (burst_err) err_pulses++;
            if (m_aw_valid && m_aw_ready)
                sb_pop("aw_xfer", {1'b0, grant_idx, 1'b0, 8'(m_aw_id), 32'd0, m_aw_addr});
            if (m_w_valid && m_w_ready) begin
                w_hs_cnt++;
                sb_pop("w_xfer", {1'b1, grant_idx, m_w_last, m_w_strb, m_w_data});
            end
            if (|s_w_ready) check("w_ready_onehot", EW'($onehot(s_w_ready)), EW'(1));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int hs0, e0, n;
        m_aw_ready = 1'b1;
        m_w_ready  = 1'b1;
        clear_model();
        repeat (3) @(posedge clk);
        #1;
        check("reset_ctrl", EW'({busy, burst_err, grant_idx, m_aw_valid, m_w_valid, m_w_last,
                                 s_aw_ready, s_w_ready, o_dbg_state}), '0);
        rst_n = 1'b1;

        // Fairness: all four keep requesting, two bursts each
        for (int i = 0; i < N; i++) load(i, 2, 'h10000 * (i + 1), 8'h80);
        for (int b = 0; b < 2; b++)
            for (int i = 0; i < N; i++) expect_burst(i, b, BL);
        run_until_done(400);
        check("fair_drain", EW'(exp_q.size()), '0);

        // Single request from requester 2
        load(2, 1, 'h1000, 8'h80);
        expect_burst(2, 0, BL);
        step();
        check("single_grant", EW'(grant_idx), EW'(2));
        check("single_busy", EW'(busy), EW'(1));
        run_until_done(100);
        check("single_busy_drop", EW'(busy), '0);

        // Backpressure on W
        load(0, 1, 'h2000, 8'h80);
        expect_burst(0, 0, BL);
        hs0 = w_hs_cnt;
        n = 0;
        while (any_left() && n < 200) begin
            step();
            m_w_ready = ~m_w_ready;
            n++;
        end
        m_w_ready = 1'b1;
        check("bp_handshakes", EW'(w_hs_cnt - hs0), EW'(8));

        // s_w_last raised early on beat 5 as well as on beat 8
        e0 = err_pulses;
        load(3, 1, 'h3000, 8'h90);
        expect_burst(3, 0, BL);
        run_until_done(100);
        step();
        step();
        check("mm_pulses", EW'(err_pulses - e0), EW'(1));

        // Early W while AW is stalled
        m_aw_ready = 1'b0;
        load(1, 1, 'h4000, 8'h80);
        expect_burst(1, 0, BL);
        step();
        for (int c = 0; c < 3; c++) begin
            check("early_w_ready", EW'(s_w_ready), '0);
            check("early_aw_valid", EW'(m_aw_valid), EW'(1));
            step();
        end
        m_aw_ready = 1'b1;
        run_until_done(100);

        // Reset in the middle of DATA
        load(0, 1, 'h5000, 8'h80);
        expect_burst(0, 0, 3);
        n = 0;
        while (beat[0] < 3 && n < 100) begin
            step();
            n++;
        end
        rst_n = 1'b0;
        #1;
        check("rst_ctrl", EW'({busy, burst_err, grant_idx, m_aw_valid, m_w_valid, m_w_last,
                               s_aw_ready, s_w_ready, o_dbg_state}), '0);
        check("rst_wdata", EW'(m_w_data), '0);
        check("rst_awaddr", EW'(m_aw_addr), '0);
        clear_model();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        load(1, 1, 'h6000, 8'h80);
        load(3, 1, 'h7000, 8'h80);
        expect_burst(1, 0, BL);
        expect_burst(3, 0, BL);
        step();
        check("rst_regrant", EW'(grant_idx), EW'(1));
        run_until_done(200);

        step();
        step();
        check("final_drain", EW'(exp_q.size()), '0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
